// File: rtl/pc_predict_unit.sv
// Next-PC selection with a direct-mapped BTB and 2-bit direction counters.
// Predicts taken branches and JAL at fetch, and redirects fetch when Execute
// resolves a different outcome.
module pc_predict_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4F_i,
  input  logic                  StallF_i,
  input  logic                  ValidE_i,
  input  logic                  BranchE_i,
  input  logic                  JumpE_i,
  input  logic                  JalrE_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic                  PredTakenE_i,
  input  logic [DATA_WIDTH-1:0] PredTargetE_i,
  output logic [DATA_WIDTH-1:0] PCNext_o,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o,
  output logic                  MispredictE_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic             btb_valid  [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] btb_target [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = PCF_i[IDX_W+1:2];
  assign f_tag = PCF_i[DATA_WIDTH-1:IDX_W+2];
  assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

  assign PredTakenF_o  = f_hit && btb_ctr[f_idx][1];
  assign PredTargetF_o = f_hit ? btb_target[f_idx] : PCPlus4F_i;

  // Execute-side resolution
  logic [DATA_WIDTH-1:0] act_target;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  ctrl_e;

  assign act_target  = JalrE_i ? ALUResultE_i : PCTargetE_i;
  assign redirect_pc = PCSrcE_i ? act_target : PCPlus4E_i;
  // JALR is excluded so it is never allocated and therefore never predicted.
  assign ctrl_e      = BranchE_i | (JumpE_i & ~JalrE_i);

  assign MispredictE_o = ValidE_i &&
                         ((PCSrcE_i != PredTakenE_i) ||
                          (PCSrcE_i && (act_target != PredTargetE_i)));

  always_comb begin
    // NOTE: default assigned first so every path drives the output and no latch is inferred.
    PCNext_o = PCPlus4F_i;
    if (MispredictE_o)     PCNext_o = redirect_pc;
    else if (StallF_i)     PCNext_o = PCF_i;
    else if (PredTakenF_o) PCNext_o = PredTargetF_o;
  end

  // Update side
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_en;
  logic             u_alloc;

  assign u_idx   = PCE_i[IDX_W+1:2];
  assign u_tag   = PCE_i[DATA_WIDTH-1:IDX_W+2];
  assign u_hit   = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
  assign u_en    = ValidE_i && ctrl_e;
  assign u_alloc = u_en && !u_hit && PCSrcE_i;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // NOTE: only valid bits and counters are reset; tags/targets are don't-care
  // while invalid, so their storage stays reset-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        // NOTE: non-blocking assignments for all sequential state.
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
      end
    end else if (u_en) begin
      if (u_hit) begin
        btb_ctr[u_idx] <= ctr_next(btb_ctr[u_idx], PCSrcE_i);
      end else if (PCSrcE_i) begin
        btb_valid[u_idx] <= 1'b1;
        btb_ctr[u_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && (u_alloc || (u_en && u_hit && PCSrcE_i))) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= PCTargetE_i;
    end
  end

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF_i[1:0], PCE_i[1:0]};

endmodule
